ami_rx_endpoint: RTL and testbench

Receiving end of the 256-bit AMI output channel of the MCSE top. It accepts `mcse_ami_out` words from the MCSE under a four-phase valid/ack handshake and drives the `ami_ack` that the MCSE consumes. Accepted words are buffered in a small FIFO. Each buffered word is then streamed to a host-side consumer as 32-bit beats under valid/ready.

---
 rtl/ami_rx_endpoint.sv | 104 ++++++++++
 tb/tb_ami_rx_endpoint.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_rx_endpoint.sv
// AMI output-channel receiver: four-phase valid/ack capture into a message
// FIFO, drained to a host consumer as HOST_W-bit beats under valid/ready.
module ami_rx_endpoint #(
  parameter int unsigned AMI_W  = 256,
  parameter int unsigned HOST_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AMI_W-1:0]         ami_data,
  input  logic                     ami_valid,
  output logic                     ami_ack,
  output logic [HOST_W-1:0]        host_data,
  output logic                     host_valid,
  output logic                     host_last,
  input  logic                     host_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty
);

  localparam int unsigned BEATS  = AMI_W / HOST_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;

  typedef enum logic {IDLE, ACKED} state_t;

  state_t              state_q, state_d;
  logic                push, pop, xfer;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    count_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [AMI_W-1:0]    mem_q [DEPTH];
  logic [AMI_W-1:0]    head;

  // Status flags derived from the registered count
  assign fifo_level = count_q;
  assign fifo_full  = (count_q == LVL_W'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // Drain side: head entry sliced LSB-first by the beat counter
  assign head       = mem_q[rd_ptr_q];
  assign host_valid = !fifo_empty;
  assign host_last  = host_valid && (beat_q == BEAT_W'(BEATS - 1));
  assign host_data  = head[beat_q*HOST_W +: HOST_W];
  assign xfer       = host_valid && host_ready;
  assign pop        = xfer && (beat_q == BEAT_W'(BEATS - 1));

  assign ami_ack    = (state_q == ACKED);

  // Handshake next-state: one capture per request, held off while full
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ami_valid && !fifo_full) begin
          state_d = ACKED;
          push    = 1'b1;
        end
      end
      ACKED: begin
        if (!ami_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Message storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= ami_data;
    end
  end

  // Pointers, occupancy and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
      if (xfer) beat_q <= pop ? '0 : beat_q + BEAT_W'(1);
    end
  end

endmodule

// File: tb/tb_ami_rx_endpoint.sv
// Directed + randomized bench for ami_rx_endpoint against a queue-based model.
module tb_ami_rx_endpoint;

  localparam int AMI_W = 256;
  localparam int HOST_W = 32;
  localparam int DEPTH = 4;
  localparam int BEATS = AMI_W / HOST_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [AMI_W-1:0]  ami_data;
  logic              ami_valid;
  logic              ami_ack;
  logic [HOST_W-1:0] host_data;
  logic              host_valid;
  logic              host_last;
  logic              host_ready;
  logic [2:0]        fifo_level;
  logic              fifo_full;
  logic              fifo_empty;

  ami_rx_endpoint #(.AMI_W(AMI_W), .HOST_W(HOST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ami_data(ami_data), .ami_valid(ami_valid), .ami_ack(ami_ack),
    .host_data(host_data), .host_valid(host_valid), .host_last(host_last),
    .host_ready(host_ready),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  // Reference model: queue of stored messages, head beat index, sender ack
  logic [AMI_W-1:0]  q[$];
  int                bidx;
  bit                ack_m;

  // Stimulus and observation
  logic [AMI_W-1:0]  tx[$];
  logic [AMI_W-1:0]  got[$];
  logic [HOST_W-1:0] beats[$];
  logic [AMI_W-1:0]  asm_buf;
  bit                auto_tx;
  int                errors = 0;
  int                checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AMI_W-1:0] rand_msg();
    logic [AMI_W-1:0] m;
    for (int i = 0; i < AMI_W / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // One clock: drive sender, update model, advance, compare everything
  task automatic step();
    bit push_m;
    logic [AMI_W-1:0] h;
    if (auto_tx) begin
      if (ami_valid && ami_ack) ami_valid = 1'b0;
      else if (!ami_valid && !ami_ack && tx.size() > 0) begin
        ami_data  = tx.pop_front();
        ami_valid = 1'b1;
      end
    end
    if (!rst && host_valid && host_ready) begin
      beats.push_back(host_data);
      asm_buf[(beats.size()-1) % BEATS * HOST_W +: HOST_W] = host_data;
      if (host_last) got.push_back(asm_buf);
    end
    if (rst) begin
      q.delete();
      bidx  = 0;
      ack_m = 1'b0;
    end else begin
      push_m = !ack_m && ami_valid && (q.size() < DEPTH);
      ack_m  = ack_m ? ami_valid : push_m;
      if (q.size() > 0 && host_ready) begin
        if (bidx == BEATS - 1) begin
          bidx = 0;
          void'(q.pop_front());
        end else bidx++;
      end
      if (push_m) q.push_back(ami_data);
    end
    @(posedge clk);
    #1;
    check("ami_ack", 64'(ami_ack), 64'(ack_m));
    check("fifo_level", 64'(fifo_level), 64'(q.size()));
    check("fifo_empty", 64'(fifo_empty), 64'(q.size() == 0));
    check("fifo_full", 64'(fifo_full), 64'(q.size() == DEPTH));
    check("host_valid", 64'(host_valid), 64'(q.size() > 0));
    check("host_last", 64'(host_last), 64'(q.size() > 0 && bidx == BEATS - 1));
    if (q.size() > 0) begin
      h = q[0];
      check("host_data", 64'(host_data), 64'(h[bidx*HOST_W +: HOST_W]));
    end else if (rst) begin
      check("host_data_rst", 64'(host_data), 64'(0));
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((tx.size() != 0 || ami_valid || ami_ack || q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", 64'(n < budget), 64'(1));
  endtask

  task automatic wait_tx_done(input int budget);
    int n = 0;
    while ((tx.size() != 0 || ami_valid || ami_ack) && n < budget) begin
      step();
      n++;
    end
    check("tx_timeout", 64'(n < budget), 64'(1));
  endtask

  initial begin
    logic [AMI_W-1:0] m;
    bit seen;
    int n;
    rst = 1'b1; ami_data = '0; ami_valid = 1'b0; host_ready = 1'b0;
    auto_tx = 1'b1; bidx = 0; ack_m = 1'b0; asm_buf = '0;

    // Reset state
    step(); step();
    rst = 1'b0;
    step();

    // Single message, byte i = i
    for (int i = 0; i < AMI_W / 8; i++) m[i*8 +: 8] = 8'(i);
    beats.delete();
    tx.push_back(m);
    host_ready = 1'b1;
    run_until_idle(100);
    check("single_nbeats", 64'(beats.size()), 64'(BEATS));
    if (beats.size() == BEATS) begin
      check("single_beat0", 64'(beats[0]), 64'(32'h03020100));
      check("single_beat1", 64'(beats[1]), 64'(32'h07060504));
      check("single_beat7", 64'(beats[7]), 64'(32'h1F1E1D1C));
    end

    // Fill and back-pressure with five requests
    host_ready = 1'b0;
    for (int i = 0; i < 5; i++) tx.push_back(rand_msg());
    repeat (24) step();
    check("fill_level", 64'(fifo_level), 64'(4));
    check("fill_full", 64'(fifo_full), 64'(1));
    check("fill_5th_ack", 64'(ami_ack), 64'(0));
    check("fill_5th_pending", 64'(ami_valid), 64'(1));
    host_ready = 1'b1;
    repeat (BEATS) step();
    host_ready = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      step();
      if (ami_ack) seen = 1'b1;
    end
    check("fill_5th_acked", 64'(seen), 64'(1));
    host_ready = 1'b1;
    run_until_idle(200);

    // Wrap-around with random host back-pressure
    got.delete();
    for (int i = 0; i < 10; i++) begin
      m = rand_msg();
      m[31:0] = 32'(i);
      tx.push_back(m);
    end
    n = 0;
    while ((tx.size() != 0 || ami_valid || ami_ack || q.size() != 0) && n < 2000) begin
      host_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("wrap_timeout", 64'(n < 2000), 64'(1));
    check("wrap_count", 64'(got.size()), 64'(10));
    for (int i = 0; i < got.size() && i < 10; i++) begin
      m = got[i];
      check($sformatf("wrap_tag%0d", i), 64'(m[31:0]), 64'(i));
    end

    // Simultaneous push and last-beat pop at level 2
    host_ready = 1'b0;
    tx.push_back(rand_msg());
    tx.push_back(rand_msg());
    wait_tx_done(50);
    check("simul_pre_level", 64'(fifo_level), 64'(2));
    auto_tx = 1'b0;
    host_ready = 1'b1;
    repeat (BEATS - 1) step();
    ami_data = rand_msg();
    ami_valid = 1'b1;
    step();
    check("simul_level", 64'(fifo_level), 64'(2));
    check("simul_ack", 64'(ami_ack), 64'(1));
    ami_valid = 1'b0;
    step();
    auto_tx = 1'b1;
    run_until_idle(200);

    // Held valid for 20 cycles: one capture only
    host_ready = 1'b0;
    auto_tx = 1'b0;
    ami_data = rand_msg();
    ami_valid = 1'b1;
    step();
    repeat (19) begin
      step();
      check("held_ack", 64'(ami_ack), 64'(1));
    end
    check("held_level", 64'(fifo_level), 64'(1));
    ami_valid = 1'b0;
    step();
    auto_tx = 1'b1;
    host_ready = 1'b1;
    run_until_idle(100);

    // Reset mid-drain with two messages queued
    host_ready = 1'b0;
    tx.push_back(rand_msg());
    tx.push_back(rand_msg());
    wait_tx_done(50);
    host_ready = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_valid", 64'(host_valid), 64'(0));
    check("rst_ack", 64'(ami_ack), 64'(0));
    rst = 1'b0;
    beats.delete();
    m = rand_msg();
    tx.push_back(m);
    run_until_idle(100);
    check("post_rst_nbeats", 64'(beats.size()), 64'(BEATS));
    if (beats.size() > 0) check("post_rst_beat0", 64'(beats[0]), 64'(m[31:0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
